// File: rtl/gpio_debounce_pkg.sv
// gpio_debounce_pkg
// Shared definitions for the GPIO input conditioner: register offsets on the
// low address nibble, the bit position where the falling-edge fields start,
// a register-select enum and helpers for address decode and pin masking.
// No ports (package).

package gpio_debounce_pkg;

    localparam logic [3:0] OFFS_DBNC_THR  = 4'h0;
    localparam logic [3:0] OFFS_EDGE_EN   = 4'h4;
    localparam logic [3:0] OFFS_EDGE_STAT = 4'h8;

    // Falling-edge enable/status bits start here; rising-edge bits start at 0.
    localparam int EDGE_FALL_BASE = 16;

    typedef enum logic [1:0] {
        REG_THR,
        REG_EN,
        REG_STAT,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decodeOffset(input logic [3:0] offs);
        case (offs)
            OFFS_DBNC_THR:  return REG_THR;
            OFFS_EDGE_EN:   return REG_EN;
            OFFS_EDGE_STAT: return REG_STAT;
            default:        return REG_NONE;
        endcase
    endfunction

    // Writable bits of EDGE_EN / EDGE_STAT: one rise bit and one fall bit
    // per implemented pin, everything else stays 0.
    function automatic logic [31:0] pinMask(input int nPins);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < nPins) begin
                mask[i]                  = 1'b1;
                mask[EDGE_FALL_BASE + i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpio_dbnc_chan.sv
// gpio_dbnc_chan
// One conditioned input: two-flop synchroniser followed by a stability
// counter. The output level only moves once the synchronised input has
// disagreed with it for thr_i+1 consecutive cycles.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   raw_i    - asynchronous pad input
//   thr_i    - debounce threshold T
//   level_o  - debounced level (registered)
//   rise_o   - single-cycle pulse in the cycle whose edge commits 0->1
//   fall_o   - single-cycle pulse in the cycle whose edge commits 1->0

module gpio_dbnc_chan
    import gpio_debounce_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             commit;

    // The compare is >= so a threshold lowered below the running count
    // commits on the very next edge instead of waiting for a wrap.
    assign commit = (s2_q != level_q) && (cnt_q >= thr_i);

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (commit) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are combinational so the status bit sets on the same edge
    // that level_o changes.
    assign level_o = level_q;
    assign rise_o  = commit & s2_q;
    assign fall_o  = commit & ~s2_q;

endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce
// Input conditioner in front of the GPIO block: per-pin synchronise and
// debounce, sticky edge status with interrupt, and a small register bank.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   we_i       - bus write strobe
//   addr_i     - bus address, only [3:0] decoded
//   data_i     - bus write data
//   data_o     - bus read data (combinational, 0 while in reset)
//   pin_raw_i  - asynchronous pad inputs
//   pin_o      - debounced levels
//   irq_o      - OR of all edge status bits

module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int          N_PINS   = 2,
    parameter int          CNT_W    = 16,
    parameter int unsigned DBNC_RST = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [N_PINS-1:0] pin_raw_i,
    output logic [N_PINS-1:0] pin_o,
    output logic              irq_o
);

    localparam logic [31:0] VALID_MASK = pinMask(N_PINS);

    reg_sel_e         regSel;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] thr_d;
    logic [31:0]      edgeEn_q;
    logic [31:0]      edgeEn_d;
    logic [31:0]      edgeStat_q;
    logic [31:0]      edgeStat_d;
    logic [31:0]      edgeSet;
    logic [31:0]      edgeClr;
    logic [31:0]      rdData;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic             unusedAddr;

    assign regSel     = decodeOffset(addr_i[3:0]);
    assign unusedAddr = ^addr_i[31:4];

    for (genvar i = 0; i < N_PINS; i++) begin : gChan
        gpio_dbnc_chan #(
            .CNT_W(CNT_W)
        ) uChan (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (pin_raw_i[i]),
            .thr_i  (thr_q),
            .level_o(pin_o[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Next-state for the register bank. Edge captures are OR'ed in after the
    // write-1-to-clear so a set and clear in the same cycle leaves the bit set.
    always_comb begin
        edgeSet = '0;
        for (int i = 0; i < N_PINS; i++) begin
            edgeSet[i]                  = rise[i] & edgeEn_q[i];
            edgeSet[EDGE_FALL_BASE + i] = fall[i] & edgeEn_q[EDGE_FALL_BASE + i];
        end

        thr_d    = thr_q;
        edgeEn_d = edgeEn_q;
        edgeClr  = '0;
        if (we_i) begin
            case (regSel)
                REG_THR:  thr_d    = data_i[CNT_W-1:0];
                REG_EN:   edgeEn_d = data_i & VALID_MASK;
                REG_STAT: edgeClr  = data_i & VALID_MASK;
                default:  ;
            endcase
        end
        edgeStat_d = (edgeStat_q & ~edgeClr) | edgeSet;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q      <= CNT_W'(DBNC_RST);
            edgeEn_q   <= '0;
            edgeStat_q <= '0;
        end else begin
            thr_q      <= thr_d;
            edgeEn_q   <= edgeEn_d;
            edgeStat_q <= edgeStat_d;
        end
    end

    // Read mux; forced to 0 while reset is held so the bus sees a quiet
    // peripheral even though thr_q holds its non-zero reset value.
    always_comb begin
        rdData = '0;
        if (rst) begin
            case (regSel)
                REG_THR:  rdData[CNT_W-1:0] = thr_q;
                REG_EN:   rdData            = edgeEn_q;
                REG_STAT: rdData            = edgeStat_q;
                default:  rdData            = '0;
            endcase
        end
    end

    assign data_o = rdData;
    assign irq_o  = |edgeStat_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce
// Directed and randomized stimulus for gpio_debounce, checked every cycle
// against a timestamp-based reference: a pin commits once its synchronised
// input has held the opposite level for at least T cycles since it last
// changed. Register bank and edge status are modelled directly from the
// register rules.

module tb_gpio_debounce;

    localparam int N_PINS = 2;
    localparam int CNT_W  = 16;
    localparam logic [31:0] VALID = 32'h0003_0003;

    logic              clk = 1'b0;
    logic              rst;
    logic              we_i;
    logic [31:0]       addr_i;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic [N_PINS-1:0] pin_raw_i;
    logic [N_PINS-1:0] pin_o;
    logic              irq_o;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    int                cycleNo = 0;
    logic [N_PINS-1:0] mS1, mS2, mLast, mPin;
    int                mSince [N_PINS];
    int unsigned       mThr;
    logic [31:0]       mEn, mStat;

    always #5 clk = ~clk;

    gpio_debounce #(
        .N_PINS  (N_PINS),
        .CNT_W   (CNT_W),
        .DBNC_RST(1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .pin_raw_i(pin_raw_i),
        .pin_o    (pin_o),
        .irq_o    (irq_o)
    );

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        case (a[3:0])
            4'h0:    return 32'(mThr);
            4'h4:    return mEn;
            4'h8:    return mStat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mS1   = '0;
        mS2   = '0;
        mLast = '0;
        mPin  = '0;
        mThr  = 1000;
        mEn   = '0;
        mStat = '0;
        for (int p = 0; p < N_PINS; p++) mSince[p] = cycleNo;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic modelEdge(input logic weV, input logic [31:0] a,
                             input logic [31:0] d, input logic [N_PINS-1:0] raw);
        logic [31:0] setV;
        logic [31:0] clrV;
        setV = '0;
        for (int p = 0; p < N_PINS; p++) begin
            if (mS2[p] !== mLast[p]) mSince[p] = cycleNo;
            mLast[p] = mS2[p];
            if (mS2[p] !== mPin[p] && (cycleNo - mSince[p]) >= int'(mThr)) begin
                mPin[p] = mS2[p];
                if (mS2[p]) setV[p] = mEn[p];
                else        setV[16 + p] = mEn[16 + p];
            end
        end
        clrV  = (weV && a[3:0] == 4'h8) ? (d & VALID) : 32'h0;
        mStat = (mStat & ~clrV) | setV;
        if (weV && a[3:0] == 4'h0) mThr = int'(d[15:0]);
        if (weV && a[3:0] == 4'h4) mEn  = d & VALID;
        mS2 = mS1;
        mS1 = raw;
        cycleNo++;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_pin"}, 32'(pin_o), 32'(mPin));
        checkValue({tag, "_irq"}, 32'(irq_o), 32'(|mStat));
        checkValue({tag, "_rd"},  data_o,     modelRead(addr_i));
    endtask

    // Drive inputs, take one clock edge, advance the model, check #1 later.
    task automatic applyStimulus(input logic weV, input logic [31:0] a,
                                 input logic [31:0] d, input logic [N_PINS-1:0] raw,
                                 input string tag);
        we_i      = weV;
        addr_i    = a;
        data_i    = d;
        pin_raw_i = raw;
        @(posedge clk);
        modelEdge(weV, a, d, raw);
        #1;
        we_i = 1'b0;
        checkOutput(tag);
    endtask

    task automatic readCheck(input logic [31:0] a, input string tag);
        addr_i = a;
        #1;
        checkValue(tag, data_o, modelRead(a));
    endtask

    initial begin
        logic [N_PINS-1:0] rnd;
        logic [31:0]       ra;
        logic [31:0]       rd;
        int unsigned       sel;
        bit                hist[$];

        rst       = 1'b0;
        we_i      = 1'b0;
        addr_i    = 32'h0;
        data_i    = 32'h0;
        pin_raw_i = '0;
        modelReset();

        // Reset state at power-up
        #12;
        checkValue("por_pin",  32'(pin_o), 32'h0);
        checkValue("por_irq",  32'(irq_o), 32'h0);
        checkValue("por_data", data_o,     32'h0);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        #1;
        checkValue("por_thr", data_o, 32'd1000);

        // Debounce latency with T=4, then a 4-cycle glitch that must be filtered
        applyStimulus(1'b1, 32'h0, 32'd4, 2'b00, "wr_thr4");
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "lat_k");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "lat");
        checkValue("lat_k5", 32'(pin_o[0]), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "lat_k6");
        checkValue("lat_k6_exact", 32'(pin_o[0]), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, "glitch");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "glitch_post");
        checkValue("glitch_hold", 32'(pin_o[0]), 32'h1);

        // Unmapped offset 0xC
        applyStimulus(1'b1, 32'hC, 32'hFFFF_FFFF, 2'b01, "wr_c");
        checkValue("rd_c", data_o, 32'h0);
        readCheck(32'h0, "rd_thr_after_c");
        checkValue("thr_after_c", data_o, 32'd4);
        readCheck(32'h4, "rd_en_after_c");

        // Zero threshold: pin 1 tracks its pad with a 2-edge delay
        applyStimulus(1'b1, 32'h0, 32'd0, 2'b01, "wr_thr0");
        for (int i = 0; i < 24; i++) begin
            rnd = {((i / 3) % 2 == 0) ? 1'b1 : 1'b0, 1'b1};
            applyStimulus(1'b0, 32'h0, 32'h0, rnd, "t0");
            hist.push_back(rnd[1]);
            if (hist.size() >= 3)
                checkValue("t0_track", 32'(pin_o[1]), 32'(hist[hist.size() - 3]));
        end

        // Edge status and interrupt
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, "settle");
        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 2'b00, "wr_en_all");
        checkValue("en_mask", data_o, 32'h0003_0003);
        applyStimulus(1'b1, 32'h4, 32'h0001_0001, 2'b00, "wr_en");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h8, 32'h0, 2'b01, "p0_high");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h8, 32'h0, 2'b00, "p0_low");
        checkValue("stat_both", data_o, 32'h0001_0001);
        checkValue("irq_both",  32'(irq_o), 32'h1);
        applyStimulus(1'b1, 32'h8, 32'h0000_0001, 2'b00, "clr_rise");
        checkValue("stat_after_clr", data_o, 32'h0001_0000);
        checkValue("irq_after_clr",  32'(irq_o), 32'h1);
        applyStimulus(1'b1, 32'h8, 32'h0, 2'b00, "wr0_stat");
        checkValue("stat_wr0", data_o, 32'h0001_0000);

        // Set/clear collision: clear bit 0 on the edge pin 0 rises
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h8, 32'h0, 2'b01, "coll_pre_hi");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h8, 32'h0, 2'b00, "coll_pre_lo");
        applyStimulus(1'b0, 32'h8, 32'h0, 2'b01, "coll_k");
        applyStimulus(1'b0, 32'h8, 32'h0, 2'b01, "coll_k1");
        applyStimulus(1'b1, 32'h8, 32'h1, 2'b01, "coll_k2");
        checkValue("coll_pin",  32'(pin_o[0]), 32'h1);
        checkValue("coll_bit0", 32'(data_o[0]), 32'h1);
        applyStimulus(1'b1, 32'h8, 32'hFFFF_FFFF, 2'b01, "clr_all");
        checkValue("stat_cleared", data_o, 32'h0);
        checkValue("irq_cleared",  32'(irq_o), 32'h0);

        // Threshold lowered mid-count: T=100, cnt reaches 50, then T=10
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, "t100_pre");
        applyStimulus(1'b1, 32'h0, 32'd100, 2'b00, "wr_thr100");
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "t100_k");
        for (int i = 0; i < 51; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "t100_cnt");
        applyStimulus(1'b1, 32'h0, 32'd10, 2'b01, "wr_thr10");
        checkValue("thr10_wr_edge", 32'(pin_o[0]), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 2'b01, "thr10_next");
        checkValue("thr10_commit", 32'(pin_o[0]), 32'h1);

        // Reset asserted mid-count
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b10, "pre_rst");
        checkValue("pre_rst_irq", 32'(irq_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkValue("rst_pin",  32'(pin_o), 32'h0);
        checkValue("rst_irq",  32'(irq_o), 32'h0);
        checkValue("rst_data", data_o,     32'h0);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        #1;
        checkValue("rst_thr", data_o, 32'd1000);
        for (int i = 0; i < 1005; i++) applyStimulus(1'b0, 32'h0, 32'h0, 2'b11, "post_rst");
        checkValue("post_rst_rise", 32'(pin_o), 32'h3);

        // Randomized traffic
        applyStimulus(1'b1, 32'h0, 32'd2, 2'b11, "rand_thr");
        rnd = 2'b11;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) rnd = N_PINS'($urandom);
            sel = $urandom_range(0, 3);
            ra  = {28'd0, 4'(sel * 4)};
            if ($urandom_range(0, 7) == 0) begin
                rd = (sel == 0) ? 32'($urandom_range(0, 6)) : $urandom;
                applyStimulus(1'b1, ra, rd, rnd, "rand_wr");
            end else begin
                applyStimulus(1'b0, ra, 32'h0, rnd, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
